hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the pipelined ARM core. It covers the decode stage (regfile read ports RA1/RA2/Rs), execute, memory and writeback.
- Generates forwarding selects for the execute-stage operands and the shift operand.
- Stalls fetch/decode on load-use hazards and pending PC writes.
- Flushes decode/execute on taken branches.
- Sequences a multi-cycle multiply in execute through an internal FSM.

Parameters:
MUL_CYCLES, 3, total execute-stage cycles for a multiply (legal range 2..15).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
RA1D  in  4  decode regfile read address 1
RA2D  in  4  decode regfile read address 2
RsD  in  4  decode shift-register address (Instr[11:8])
UsesRsD  in  1  decode instruction reads RsD
RA1E  in  4  execute-stage copy of RA1
RA2E  in  4  execute-stage copy of RA2
RsE  in  4  execute-stage copy of Rs
RdE  in  4  execute destination
RegWriteE  in  1  execute writes Rd
MemtoRegE  in  1  execute is a load
RdM  in  4  memory destination
RegWriteM  in  1  memory writes Rd
RdW  in  4  writeback destination
RegWriteW  in  1  writeback writes Rd
PCSrcD  in  1  decode writes PC
PCSrcE  in  1  execute writes PC
PCSrcM  in  1  memory writes PC
PCSrcW  in  1  writeback writes PC
BranchTakenE  in  1  branch resolved taken in execute
MulStartE  in  1  valid multiply in execute (condition passed)
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
ForwardSE  out  2  shift-operand select, same encoding
StallF  out  1  hold fetch PC
StallD  out  1  hold decode pipeline register
StallE  out  1  hold execute pipeline register
FlushD  out  1  clear decode pipeline register
FlushE  out  1  clear execute pipeline register
FlushM  out  1  clear memory pipeline register
MulBusy  out  1  multiply sequencing in progress
MulDoneE  out  1  one-cycle pulse in final multiply cycle

Behaviour:
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM & RdM==RA1E & RA1E!=15.
- Else ForwardAE = 01 if RegWriteW & RdW==RA1E & RA1E!=15.
- Else ForwardAE = 00.
- ForwardBE uses RA2E and ForwardSE uses RsE with the identical rule.
- R15 is never forwarded (the regfile supplies PCPlus8).
- When M and W both match, M wins.

Load-use (combinational):
- ldrStall = MemtoRegE & RegWriteE & (RA1D==RdE | RA2D==RdE | (UsesRsD & RsD==RdE)).
- ldrStall is forced 0 while MulBusy.

PC pending:
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.

Multiply FSM:
- States: IDLE and MUL.
- Down-counter cnt[3:0].
- IDLE -> MUL when MulStartE=1; cnt loads MUL_CYCLES-1.
- MUL: cnt decrements each cycle. When cnt==1, MulDoneE=1 and next state is IDLE.
- MulStartE is ignored while in MUL.
- MulBusy=1 in MUL, and also in the IDLE cycle where MulStartE=1, so the stall starts in the same cycle as the start.
- mulStall = MulBusy & ~MulDoneE. The instruction leaves E in the cycle MulDoneE is high.
- MUL_CYCLES=2 gives exactly one stall cycle.

Outputs:
- StallF = ldrStall | PCWrPending | mulStall.
- StallD = ldrStall | mulStall.
- StallE = mulStall.
- FlushD = PCWrPending | PCSrcW | (BranchTakenE & ~mulStall).
- FlushE = ldrStall | (BranchTakenE & ~mulStall).
- FlushM = mulStall (bubbles into M while E holds).
- When a stage's Stall and Flush are both asserted, flush wins; the datapath must honour this priority.

Reset:
- Synchronous, active-high.
- State=IDLE, cnt=0, so MulBusy=0 and MulDoneE=0.
- Reset asserted mid-multiply aborts it: all stall/flush outputs from the FSM drop in the cycle after reset is sampled.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt[31:0] (counts cycles with StallD=1) and FlushCnt[31:0] (counts cycles with FlushE=1).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Forwarding priority: RegWriteM=1, RdM=3; RegWriteW=1, RdW=3; RA1E=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RA1E=15 -> ForwardAE=00.
2. Load-use on Rs: MemtoRegE=1, RegWriteE=1, RdE=5; UsesRsD=1, RsD=5 -> StallF=StallD=FlushE=1 for one cycle. With UsesRsD=0 -> no stall.
3. Multiply, MUL_CYCLES=3: MulStartE=1 at cycle 0 -> StallE=FlushM=1 in cycles 0–1; MulDoneE=1 and stalls low in cycle 2; back in IDLE in cycle 3.
4. Branch flush: BranchTakenE=1 while IDLE -> FlushD=FlushE=1. BranchTakenE=1 during a multiply stall cycle -> FlushE=0.
5. PC write: PCSrcD=1 at cycle 0, then PCSrcE, PCSrcM, PCSrcW on successive cycles -> StallF=1 for cycles 0–2; FlushD=1 for cycles 0–3.
6. Reset: assert reset at the second cycle of a MUL_CYCLES=4 multiply -> next cycle MulBusy=0, StallE=0; with HAZARD_PERF_CNT_EN, StallCnt=0 and FlushCnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: pipeline register addresses, PC-write flags, stall/flush/forward outputs.
// StallCnt/FlushCnt exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic [3:0] RsD;
  logic       UsesRsD;
  logic [3:0] RA1E;
  logic [3:0] RA2E;
  logic [3:0] RsE;
  logic [3:0] RdE;
  logic       RegWriteE;
  logic       MemtoRegE;
  logic [3:0] RdM;
  logic       RegWriteM;
  logic [3:0] RdW;
  logic       RegWriteW;
  logic       PCSrcD;
  logic       PCSrcE;
  logic       PCSrcM;
  logic       PCSrcW;
  logic       BranchTakenE;
  logic       MulStartE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic [1:0] ForwardSE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       MulBusy;
  logic       MulDoneE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
`endif

  modport master (
    output RA1D, RA2D, RsD, UsesRsD,
    output RA1E, RA2E, RsE, RdE,
    output RegWriteE, MemtoRegE,
    output RdM, RegWriteM, RdW, RegWriteW,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    output BranchTakenE, MulStartE,
    input  ForwardAE, ForwardBE, ForwardSE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  MulBusy, MulDoneE
`ifdef HAZARD_PERF_CNT_EN
    , input StallCnt, FlushCnt
`endif
  );

  modport slave (
    input  RA1D, RA2D, RsD, UsesRsD,
    input  RA1E, RA2E, RsE, RdE,
    input  RegWriteE, MemtoRegE,
    input  RdM, RegWriteM, RdW, RegWriteW,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    input  BranchTakenE, MulStartE,
    output ForwardAE, ForwardBE, ForwardSE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output MulBusy, MulDoneE
`ifdef HAZARD_PERF_CNT_EN
    , output StallCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use/PC stalls, branch flushes and multi-cycle multiply sequencing.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] r,
    input logic       wm,
    input logic [3:0] rdm,
    input logic       ww,
    input logic [3:0] rdw
  );
    logic m_hit;
    logic w_hit;
    // R15 reads come from PCPlus8, never from the bypass
    m_hit = wm & (rdm == r) & (r != 4'd15);
    w_hit = ww & (rdw == r) & (r != 4'd15) & ~m_hit;
    fwd_sel = 2'b00;
    unique case (1'b1)
      m_hit:   fwd_sel = 2'b10;
      w_hit:   fwd_sel = 2'b01;
      default: fwd_sel = 2'b00;
    endcase
  endfunction

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       mul_busy;
  logic       mul_done;
  logic       mul_stall;
  logic       ldr_stall;
  logic       pc_pend;
  logic       br_flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hz.MulStartE) begin
          mul_busy  = 1'b1;
          state_nxt = MUL;
          cnt_nxt   = 4'(MUL_CYCLES - 1);
        end
      end
      MUL: begin
        mul_busy = 1'b1;
        cnt_nxt  = cnt - 4'd1;
        if (cnt == 4'd1) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign mul_stall = mul_busy & ~mul_done;

  assign ldr_stall = ~mul_busy
                   & hz.MemtoRegE & hz.RegWriteE
                   & ((hz.RA1D == hz.RdE)
                    | (hz.RA2D == hz.RdE)
                    | (hz.UsesRsD & (hz.RsD == hz.RdE)));

  assign pc_pend  = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign br_flush = hz.BranchTakenE & ~mul_stall;

  assign hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWriteM, hz.RdM,
                                hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWriteM, hz.RdM,
                                hz.RegWriteW, hz.RdW);
  assign hz.ForwardSE = fwd_sel(hz.RsE, hz.RegWriteM, hz.RdM,
                                hz.RegWriteW, hz.RdW);

  assign hz.StallF   = ldr_stall | pc_pend | mul_stall;
  assign hz.StallD   = ldr_stall | mul_stall;
  assign hz.StallE   = mul_stall;
  assign hz.FlushD   = pc_pend | hz.PCSrcW | br_flush;
  assign hz.FlushE   = ldr_stall | br_flush;
  assign hz.FlushM   = mul_stall;
  assign hz.MulBusy  = mul_busy;
  assign hz.MulDoneE = mul_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (hz.StallD && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (hz.FlushE && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`endif

endmodule
